// File: rtl/bg_ocm_responder.sv
// bg_ocm_responder: on-chip background memory, one 32-bit single-port RAM.
// The RAM is shared between an Avalon-MM slave and a pixel-side byte reader.
// The pixel reader wins by default. A stalled Avalon request is granted once
// it has waited STARVE_MAX cycles.
// Both read paths have a fixed latency of two cycles: a registered RAM
// output, then a registered output stage.
//
// Ports
//   Clk, Reset                 single clock, asynchronous active-high reset
//   avs_address/write/read     Avalon-MM request (word address)
//   avs_writedata/byteenable   write payload
//   avs_readdata/readdatavalid read response, latency 2
//   avs_waitrequest            combinational stall for the current request
//   vga_port_local_addr        pixel byte address
//   pix_req                    pixel read request
//   vga_port_backgrounddata    returned byte, held between valid cycles
//   pix_valid                  qualifies vga_port_backgrounddata
module bg_ocm_responder #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned STARVE_MAX = 7
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic              avs_waitrequest,
    input  logic [ADDR_W+1:0] vga_port_local_addr,
    input  logic              pix_req,
    output logic [7:0]        vga_port_backgrounddata,
    output logic              pix_valid
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned CntW  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

    // Arbitration
    logic              avs_req;
    logic              starve;
    logic              avs_gnt;
    logic              avs_wr_gnt;
    logic              avs_rd_gnt;
    logic              pix_gnt;
    logic [ADDR_W-1:0] ram_addr;
    logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;

    always_comb begin
        avs_req = avs_read | avs_write;
        starve  = avs_req && (starve_cnt_q == StarveMax);
        // Reset gating keeps the RAM untouched while Reset is held.
        avs_gnt    = avs_req && (!pix_req || starve) && !Reset;
        // Write wins when read and write arrive together.
        avs_wr_gnt = avs_gnt && avs_write;
        avs_rd_gnt = avs_gnt && !avs_write;
        pix_gnt    = pix_req && !starve && !Reset;
        avs_waitrequest = avs_req && !avs_gnt && !Reset;
        ram_addr = avs_gnt ? avs_address : vga_port_local_addr[ADDR_W+1:2];
        starve_cnt_d = (avs_req && !avs_gnt) ? starve_cnt_q + CntW'(1) : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // RAM with registered read port; deliberately not reset.
    logic [31:0] mem [Depth];
    logic [31:0] mem_rdata_q;

    always_ff @(posedge Clk) begin
        if (avs_wr_gnt) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_byteenable[b]) begin
                    mem[ram_addr][8*b +: 8] <= avs_writedata[8*b +: 8];
                end
            end
        end
        if (avs_rd_gnt || pix_gnt) begin
            mem_rdata_q <= mem[ram_addr];
        end
    end

    // Stage 1: valids and byte select travel alongside the RAM read.
    logic       avs_v1_q;
    logic       pix_v1_q;
    logic [1:0] pix_sel1_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            avs_v1_q   <= 1'b0;
            pix_v1_q   <= 1'b0;
            pix_sel1_q <= 2'b00;
        end else begin
            avs_v1_q   <= avs_rd_gnt;
            pix_v1_q   <= pix_gnt;
            pix_sel1_q <= vga_port_local_addr[1:0];
        end
    end

    logic [7:0] pix_byte;

    always_comb begin
        pix_byte = mem_rdata_q[7:0];
        unique case (pix_sel1_q)
            2'd0: pix_byte = mem_rdata_q[7:0];
            2'd1: pix_byte = mem_rdata_q[15:8];
            2'd2: pix_byte = mem_rdata_q[23:16];
            2'd3: pix_byte = mem_rdata_q[31:24];
            default: pix_byte = mem_rdata_q[7:0];
        endcase
    end

    // Stage 2: output registers; data holds between valid cycles.
    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic [7:0]  bg_q;
    logic        pvalid_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            bg_q     <= '0;
            pvalid_q <= 1'b0;
        end else begin
            rvalid_q <= avs_v1_q;
            pvalid_q <= pix_v1_q;
            if (avs_v1_q) begin
                rdata_q <= mem_rdata_q;
            end
            if (pix_v1_q) begin
                bg_q <= pix_byte;
            end
        end
    end

    assign avs_readdata            = rdata_q;
    assign avs_readdatavalid       = rvalid_q;
    assign vga_port_backgrounddata = bg_q;
    assign pix_valid               = pvalid_q;

endmodule

// File: tb/tb_bg_ocm_responder.sv
module tb_bg_ocm_responder;

    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned STARVE_MAX = 7;
    localparam int          NWORDS     = 64;  // bench only touches this window

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] avs_address = '0;
    logic              avs_write = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [3:0]        avs_byteenable = '0;
    logic              avs_read = 1'b0;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic              avs_waitrequest;
    logic [ADDR_W+1:0] vga_addr = '0;
    logic              pix_req = 1'b0;
    logic [7:0]        bg_data;
    logic              pix_valid;

    always #5 clk = ~clk;

    bg_ocm_responder #(
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .Clk                    (clk),
        .Reset                  (rst),
        .avs_address            (avs_address),
        .avs_write              (avs_write),
        .avs_writedata          (avs_writedata),
        .avs_byteenable         (avs_byteenable),
        .avs_read               (avs_read),
        .avs_readdata           (avs_readdata),
        .avs_readdatavalid      (avs_readdatavalid),
        .avs_waitrequest        (avs_waitrequest),
        .vga_port_local_addr    (vga_addr),
        .pix_req                (pix_req),
        .vga_port_backgrounddata(bg_data),
        .pix_valid              (pix_valid)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory image, response schedule indexed by cycle, stall count.
    logic [31:0] mem_m [NWORDS];
    bit          sv_avs [4];
    logic [31:0] sv_rd  [4];
    bit          sv_pix [4];
    logic [7:0]  sv_bg  [4];
    logic [31:0] exp_rd = '0;
    logic [7:0]  exp_bg = '0;
    int          stall = 0;
    int          cyc = 0;
    bit          last_wait = 0;
    int          pix_seen = 0;
    int          wait_seen = 0;

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            sv_avs[i] = 0;
            sv_pix[i] = 0;
        end
        exp_rd = '0;
        exp_bg = '0;
        stall  = 0;
        last_wait = 0;
    endtask

    // One clock cycle: check outputs mid-cycle, predict, then advance past the edge.
    task automatic cycle();
        bit areq, ag, pg;
        int s, w, bsel, a;
        @(negedge clk);
        s = cyc % 4;
        if (sv_avs[s]) exp_rd = sv_rd[s];
        if (sv_pix[s]) exp_bg = sv_bg[s];
        check_val("rvalid", 32'(avs_readdatavalid), 32'(sv_avs[s]));
        check_val("rdata", avs_readdata, exp_rd);
        check_val("pvalid", 32'(pix_valid), 32'(sv_pix[s]));
        check_val("bgdata", 32'(bg_data), 32'(exp_bg));
        if (pix_valid) pix_seen++;
        if (avs_waitrequest) wait_seen++;
        sv_avs[s] = 0;
        sv_pix[s] = 0;

        areq = avs_read || avs_write;
        ag   = areq && (!pix_req || stall == STARVE_MAX);
        pg   = pix_req && !(areq && stall == STARVE_MAX);
        check_val("waitreq", 32'(avs_waitrequest), 32'(areq && !ag));
        last_wait = areq && !ag;
        stall = last_wait ? stall + 1 : 0;

        s = (cyc + 2) % 4;
        a = int'(avs_address);
        if (ag && avs_write) begin
            for (int b = 0; b < 4; b++)
                if (avs_byteenable[b]) mem_m[a][8*b +: 8] = avs_writedata[8*b +: 8];
        end else if (ag) begin
            sv_avs[s] = 1;
            sv_rd[s]  = mem_m[a];
        end
        if (pg) begin
            w    = int'(vga_addr) / 4;
            bsel = int'(vga_addr) % 4;
            sv_pix[s] = 1;
            sv_bg[s]  = mem_m[w][8*bsel +: 8];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold an Avalon request until the model says it is granted (bounded).
    task automatic avs_op(input bit wr, input bit rd, input int addr, input logic [31:0] data,
                          input logic [3:0] be);
        avs_write = wr;
        avs_read = rd;
        avs_address = ADDR_W'(addr);
        avs_writedata = data;
        avs_byteenable = be;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (!last_wait) break;
        end
        avs_write = 0;
        avs_read = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_val("rst_rvalid", 32'(avs_readdatavalid), 0);
            check_val("rst_rdata", avs_readdata, 0);
            check_val("rst_pvalid", 32'(pix_valid), 0);
            check_val("rst_bg", 32'(bg_data), 0);
            check_val("rst_waitreq", 32'(avs_waitrequest), 0);
            @(posedge clk);
            #1;
        end
        avs_write = 0;
        avs_read = 0;
        pix_req = 0;
        rst = 0;
        clear_model();
    endtask

    initial begin
        clear_model();
        // Reset with requests pending: waitrequest must stay low.
        @(posedge clk);
        #1;
        avs_read = 1;
        avs_write = 1;
        pix_req = 1;
        do_reset(3);

        // Fill the working window.
        for (int i = 0; i < NWORDS; i++) avs_op(1, 0, i, $urandom, 4'hF);

        // Write then read back word 0x10.
        avs_op(1, 0, 'h10, 32'hA1B2C3D4, 4'hF);
        avs_op(0, 1, 'h10, '0, 4'h0);
        idle(3);
        check_val("rd_a1b2c3d4", avs_readdata, 32'hA1B2C3D4);

        // Pixel bytes 0x40..0x43 back-to-back.
        pix_req = 1;
        for (int i = 0; i < 4; i++) begin
            vga_addr = (ADDR_W + 2)'('h40 + i);
            cycle();
        end
        pix_req = 0;
        idle(3);
        check_val("pix_last_a1", 32'(bg_data), 32'h000000A1);

        // Partial byte-enable write.
        avs_op(1, 0, 'h10, 32'hFFFFFFFF, 4'b0101);
        avs_op(0, 1, 'h10, '0, 4'h0);
        idle(3);
        check_val("rd_be0101", avs_readdata, 32'hA1FFC3FF);

        // Starvation: pixel held while a write waits.
        pix_seen = 0;
        wait_seen = 0;
        pix_req = 1;
        vga_addr = (ADDR_W + 2)'('h40);
        avs_op(1, 0, 'h11, 32'h5A5A5A5A, 4'hF);
        idle(2);
        pix_req = 0;
        idle(3);
        check_val("starve_waits", 32'(wait_seen), STARVE_MAX);
        check_val("starve_pix_count", 32'(pix_seen), 32'(STARVE_MAX + 2));

        // Reset one cycle after a pixel grant; RAM must survive.
        pix_req = 1;
        vga_addr = (ADDR_W + 2)'('h41);
        cycle();
        pix_req = 0;
        do_reset(1);
        pix_seen = 0;
        idle(4);
        check_val("rst_no_pix", 32'(pix_seen), 0);
        avs_op(0, 1, 'h10, '0, 4'h0);
        idle(3);
        check_val("rst_ram_kept", avs_readdata, 32'hA1FFC3FF);

        // Write then pixel read of the same word on the next cycle.
        avs_op(1, 0, 5, 32'h9C000000, 4'b1000);
        pix_req = 1;
        vga_addr = (ADDR_W + 2)'(5 * 4 + 3);
        cycle();
        pix_req = 0;
        idle(3);
        check_val("raw_pix", 32'(bg_data), 32'h0000009C);

        // Randomized traffic; stalled Avalon requests are held stable.
        for (int n = 0; n < 400; n++) begin
            if (!last_wait) begin
                int r;
                r = $urandom_range(0, 5);
                avs_write = (r == 2 || r == 3);
                avs_read = (r == 1 || r == 3);
                avs_address = ADDR_W'($urandom_range(0, NWORDS - 1));
                avs_writedata = $urandom;
                avs_byteenable = 4'($urandom);
            end
            pix_req = ($urandom_range(0, 9) < 8);
            vga_addr = (ADDR_W + 2)'($urandom_range(0, NWORDS * 4 - 1));
            cycle();
        end
        avs_write = 0;
        avs_read = 0;
        pix_req = 0;
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bg_ocm_responder.md
BG_OCM_RESPONDER -- requirements
Module: bg_ocm_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, the word-address width (2^ADDR_W 32-bit words; 14 gives 64 KB).
REQ-002 SHALL have parameter STARVE_MAX, default 7, the maximum consecutive stalled cycles of a pending Avalon request before Avalon is granted.
REQ-003 SHALL have port Clk  in  1  system clock (MAX10_CLK1_50 domain); single clock domain.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port avs_address  in  ADDR_W  Avalon-MM word address.
REQ-006 SHALL have port avs_write  in  1  Avalon write request.
REQ-007 SHALL have port avs_writedata  in  32  write data.
REQ-008 SHALL have port avs_byteenable  in  4  byte-lane enables for writes.
REQ-009 SHALL have port avs_read  in  1  Avalon read request.
REQ-010 SHALL have port avs_readdata  out  32  read data.
REQ-011 SHALL have port avs_readdatavalid  out  1  read data qualifier.
REQ-012 SHALL have port avs_waitrequest  out  1  stall for the current Avalon request.
REQ-013 SHALL have port vga_port_local_addr  in  ADDR_W+2  byte address from the pixel-side reader.
REQ-014 SHALL have port pix_req  in  1  pixel read request for vga_port_local_addr.
REQ-015 SHALL have port vga_port_backgrounddata  out  8  background byte returned to the pixel reader.
REQ-016 SHALL have port pix_valid  out  1  qualifies vga_port_backgrounddata.

Function
REQ-017 SHALL contain one single-port RAM of 2^ADDR_W x 32 bits with a registered output; contents are not initialised by Reset.
REQ-018 SHALL arbitrate one RAM access per cycle between three requesters: pix_req, avs_read and avs_write.
REQ-019 SHALL treat avs_read and avs_write asserted together as a protocol error: write wins and the read is ignored.
REQ-020 SHALL grant the pixel request by default when pix_req=1, and SHALL assert avs_waitrequest=1 combinationally for any Avalon request in that cycle.
REQ-021 SHALL keep a starvation counter (width ceil(log2(STARVE_MAX+1))) that increments each cycle an Avalon request is stalled and clears on an Avalon grant or when no Avalon request is present.
REQ-022 SHALL grant Avalon in the cycle the counter equals STARVE_MAX, even when pix_req=1; in that cycle the pixel request is dropped (no pix_valid two cycles later) and vga_port_backgrounddata holds its previous value.
REQ-023 SHALL, on an Avalon grant, deassert avs_waitrequest in that cycle; the request completes there.
REQ-024 SHALL, on a granted write, update only the byte lanes whose avs_byteenable bit is 1.
REQ-025 SHALL return a granted Avalon read with fixed latency 2: avs_readdatavalid=1 for exactly one cycle, two cycles after the grant edge, with avs_readdata = RAM word.
REQ-026 SHALL serve a granted pixel read from word vga_port_local_addr[ADDR_W+1:2], with the byte selected by [1:0] (00 = bits 7:0 ... 11 = bits 31:24) registered alongside the RAM read.
REQ-027 SHALL assert pix_valid=1 for one cycle, two cycles after the grant edge, and SHALL hold vga_port_backgrounddata between valid cycles.
REQ-028 SHALL give read-after-write the new data: a read granted in the cycle after a write to the same word returns the written bytes.
REQ-029 SHALL sustain one pixel read per cycle (fully pipelined) whenever no starvation grant occurs.
REQ-030 SHALL wrap address arithmetic modulo 2^ADDR_W; no out-of-range behaviour exists.

Reset
REQ-031 SHALL, while Reset=1, force avs_readdatavalid=0, pix_valid=0, avs_readdata=0, vga_port_backgrounddata=0, avs_waitrequest=0, the starvation counter=0 and both pipeline valid stages to 0.
REQ-032 SHALL discard any in-flight read on a Reset mid-operation (no valid output after release) and SHALL leave RAM contents intact.
REQ-033 SHALL accept requests from the first rising Clk edge after Reset deasserts.

Verification
REQ-034 SHALL be verified by: Avalon write word 0x0010 = 0xA1B2C3D4, be=1111, pix_req idle -> waitrequest=0; avs_read 0x0010 -> readdatavalid 2 cycles later, readdata=0xA1B2C3D4.
REQ-035 SHALL be verified by: pixel reads of byte addresses 0x0040..0x0043 on consecutive cycles -> pix_valid on 4 consecutive cycles with data D4, C3, B2, A1.
REQ-036 SHALL be verified by: write 0xFFFFFFFF be=0101 over 0xA1B2C3D4 -> readback 0xA1FFC3FF.
REQ-037 SHALL be verified by: pix_req held 1 and avs_write held 1 -> waitrequest=1 for 7 cycles, write granted on the 8th, exactly one pix_valid missing, and the byte is held.
REQ-038 SHALL be verified by: Reset pulsed one cycle after a pixel grant -> no pix_valid follows, RAM word unchanged on readback.
REQ-039 SHALL be verified by: write followed next cycle by a pixel read of the same word -> the new byte is returned.
